hash_sequencer: RTL and testbench

HASH_SEQUENCER -- requirements
Module: hash_sequencer

---
 rtl/hash_sequencer_if.sv | 38 +++
 rtl/hash_sequencer.sv | 139 +++++++++++++
 tb/tb_hash_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_sequencer_if.sv
// Control and handshake bundle between the hash sequencer, the message source,
// the hash core and the digest sink.
interface hash_sequencer_if #(
   parameter int ROUNDS       = 64,
   parameter int DIGEST_WORDS = 8
);
   localparam int RW = ($clog2(ROUNDS) < 1) ? 1 : $clog2(ROUNDS);
   localparam int OW = ($clog2(DIGEST_WORDS) < 1) ? 1 : $clog2(DIGEST_WORDS);

   logic          start;
   logic          first_block;
   logic          last_block;
   logic          abort;
   logic          in_valid;
   logic          in_ready;
   logic          round_en;
   logic [RW-1:0] round_idx;
   logic          init_hash;
   logic          update_hash;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_idx;
   logic          busy;
   logic          done;
   logic          err;

   modport slave (
      input  start, first_block, last_block, abort, in_valid, out_ready,
      output in_ready, round_en, round_idx, init_hash, update_hash,
             out_valid, out_idx, busy, done, err
   );

   modport master (
      output start, first_block, last_block, abort, in_valid, out_ready,
      input  in_ready, round_en, round_idx, init_hash, update_hash,
             out_valid, out_idx, busy, done, err
   );
endinterface

// File: rtl/hash_sequencer.sv
// Block sequencer for an iterated hash: loads message words, steps the rounds,
// folds the result into the hash state and streams out the digest words.
module hash_sequencer #(
   parameter int LOAD_WORDS   = 16,
   parameter int ROUNDS       = 64,
   parameter int DIGEST_WORDS = 8
) (
   input logic             clk,
   input logic             reset_n,
   hash_sequencer_if.slave bus
);
   localparam int RW = ($clog2(ROUNDS) < 1) ? 1 : $clog2(ROUNDS);
   localparam int OW = ($clog2(DIGEST_WORDS) < 1) ? 1 : $clog2(DIGEST_WORDS);
   localparam int WW = ($clog2(LOAD_WORDS) < 1) ? 1 : $clog2(LOAD_WORDS);

   localparam logic [WW-1:0] LAST_WORD  = WW'(LOAD_WORDS - 1);
   localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
   localparam logic [OW-1:0] LAST_OUT   = OW'(DIGEST_WORDS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, OUT} state_t;

   state_t        state_q;
   state_t        state_d;
   logic [1:0]    sync_q;
   logic          run;
   logic [WW-1:0] word_cnt;
   logic [RW-1:0] round_cnt;
   logic [OW-1:0] out_cnt;
   logic          msg_open;
   logic          last_q;
   logic          init_q;
   logic          done_q;
   logic          err_q;
   logic          accept;
   logic          start_ok;
   logic          out_fire;

   // Reset release is staged through two flops so nothing moves before the
   // second rising edge after reset_n rises.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 2'b00;
      else          sync_q <= {sync_q[0], 1'b1};
   end

   assign run      = sync_q[1];
   assign accept   = (state_q == LOAD) && bus.in_valid;
   assign out_fire = (state_q == OUT) && bus.out_ready;
   assign start_ok = bus.start && (bus.first_block || msg_open);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  state_q <= IDLE;
      else if (run)  state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (accept && word_cnt == LAST_WORD) state_d = ROUND;
            ROUND:   if (round_cnt == LAST_ROUND) state_d = UPDATE;
            UPDATE:  state_d = last_q ? OUT : IDLE;
            OUT:     if (out_fire && out_cnt == LAST_OUT) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Counters, the open-message flag and the registered pulses; abort wipes
   // the block so a later continuation start is rejected.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_cnt  <= '0;
         round_cnt <= '0;
         out_cnt   <= '0;
         msg_open  <= 1'b0;
         last_q    <= 1'b0;
         init_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else if (run) begin
         init_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (bus.abort) begin
            word_cnt  <= '0;
            round_cnt <= '0;
            out_cnt   <= '0;
            msg_open  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_ok) begin
                     last_q   <= bus.last_block;
                     init_q   <= bus.first_block;
                     word_cnt <= '0;
                  end else if (bus.start) begin
                     err_q <= 1'b1;
                  end
               end
               LOAD: begin
                  if (accept) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
               end
               ROUND: begin
                  round_cnt <= (round_cnt == LAST_ROUND) ? '0 : round_cnt + 1'b1;
               end
               UPDATE: begin
                  msg_open <= 1'b1;
               end
               OUT: begin
                  if (out_fire) begin
                     if (out_cnt == LAST_OUT) begin
                        out_cnt  <= '0;
                        msg_open <= 1'b0;
                        done_q   <= 1'b1;
                     end else begin
                        out_cnt <= out_cnt + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready    = (state_q == LOAD);
   assign bus.round_en    = (state_q == ROUND);
   assign bus.round_idx   = round_cnt;
   assign bus.init_hash   = init_q;
   assign bus.update_hash = (state_q == UPDATE);
   assign bus.out_valid   = (state_q == OUT);
   assign bus.out_idx     = out_cnt;
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_hash_sequencer.sv
// Scoreboard bench for hash_sequencer: a protocol-level model predicts the event
// stream per block and a negedge monitor compares what the sequencer emits.
module tb_hash_sequencer;
   localparam int LW = 16;
   localparam int R  = 64;
   localparam int DW = 8;

   localparam int EV_INIT   = 1;
   localparam int EV_LOAD   = 2;
   localparam int EV_ROUNDS = 3;
   localparam int EV_UPDATE = 4;
   localparam int EV_WORD   = 5;
   localparam int EV_DONE   = 6;
   localparam int EV_ERR    = 7;

   typedef struct {int kind; int val;} ev_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   ev_t  exp_q[$];
   bit   model_open = 1'b0;

   int   iv_mode = 0;
   int   or_mode = 0;
   int   hold_cnt = 0;
   bit   iv_phase = 1'b0;

   int   t_init, t_r0, t_rlast, t_upd, t_o0, t_olast, t_done;
   int   stall4 = 0;

   hash_sequencer_if #(.ROUNDS(R), .DIGEST_WORDS(DW)) m_if ();
   hash_sequencer_if #(.ROUNDS(8), .DIGEST_WORDS(5))  s_if ();

   hash_sequencer #(.LOAD_WORDS(LW), .ROUNDS(R), .DIGEST_WORDS(DW)) dut (
      .clk(clk), .reset_n(reset_n), .bus(m_if)
   );

   hash_sequencer #(.LOAD_WORDS(4), .ROUNDS(8), .DIGEST_WORDS(5)) dut_small (
      .clk(clk), .reset_n(reset_n), .bus(s_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void checkOutput(string name, int actual, int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endfunction

   function automatic void pushEv(int kind, int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endfunction

   // Expected event stream for one block, straight from the protocol rules.
   function automatic void pushModel(bit first, bit last, int stop_at, bit use_reset);
      if (!first && !model_open) begin
         pushEv(EV_ERR, 0);
         return;
      end
      if (first) pushEv(EV_INIT, 0);
      pushEv(EV_LOAD, LW);
      if (stop_at >= 0) begin
         pushEv(EV_ROUNDS, use_reset ? stop_at : stop_at + 1);
         model_open = 1'b0;
         return;
      end
      pushEv(EV_ROUNDS, R);
      pushEv(EV_UPDATE, 0);
      if (last) begin
         for (int i = 0; i < DW; i++) pushEv(EV_WORD, i);
         pushEv(EV_DONE, 0);
         model_open = 1'b0;
      end else begin
         model_open = 1'b1;
      end
   endfunction

   function automatic void observe(int kind, int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         checkOutput("unexpected_event", kind, -1);
         return;
      end
      e = exp_q.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_val", val, e.val);
   endfunction

   // Background drivers for the upstream valid and downstream ready.
   initial begin
      m_if.in_valid  = 1'b0;
      m_if.out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (iv_mode)
            0:       m_if.in_valid = 1'b1;
            1:       begin iv_phase = ~iv_phase; m_if.in_valid = iv_phase; end
            default: m_if.in_valid = 1'($urandom % 2);
         endcase
         case (or_mode)
            0: m_if.out_ready = 1'b1;
            1: begin
               if (m_if.out_valid && m_if.out_idx == 3'd4 && hold_cnt < 3) begin
                  m_if.out_ready = 1'b0;
                  hold_cnt++;
               end else begin
                  m_if.out_ready = 1'b1;
               end
            end
            default: m_if.out_ready = 1'($urandom % 4 != 0);
         endcase
      end
   end

   // Monitor: turns sequencer activity into events and pops the scoreboard.
   bit round_prev = 1'b0;
   int run_len = 0;
   bit seq_ok = 1'b1;
   int load_cnt = 0;
   bit prev_stall = 1'b0;
   int prev_idx = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (m_if.init_hash) begin observe(EV_INIT, 0); t_init = cyc; end
         if (m_if.in_valid && m_if.in_ready) load_cnt++;
         if (m_if.round_en) begin
            if (!round_prev) begin
               observe(EV_LOAD, load_cnt);
               load_cnt = 0;
               run_len  = 0;
               seq_ok   = 1'b1;
            end
            if (int'(m_if.round_idx) != run_len) seq_ok = 1'b0;
            if (m_if.round_idx == 0) t_r0 = cyc;
            if (int'(m_if.round_idx) == R - 1) t_rlast = cyc;
            run_len++;
         end else if (round_prev) begin
            observe(EV_ROUNDS, seq_ok ? run_len : -1);
         end
         round_prev = m_if.round_en;
         if (m_if.update_hash) begin observe(EV_UPDATE, 0); t_upd = cyc; end
         if (prev_stall && m_if.out_valid) checkOutput("out_idx_hold", int'(m_if.out_idx), prev_idx);
         if (m_if.out_valid && !m_if.out_ready && m_if.out_idx == 3'd4) stall4++;
         if (m_if.out_valid && m_if.out_ready) begin
            observe(EV_WORD, int'(m_if.out_idx));
            if (m_if.out_idx == 0) t_o0 = cyc;
            if (int'(m_if.out_idx) == DW - 1) t_olast = cyc;
         end
         prev_stall = m_if.out_valid && !m_if.out_ready;
         prev_idx   = int'(m_if.out_idx);
         if (m_if.done) begin observe(EV_DONE, 0); t_done = cyc; end
         if (m_if.err) begin
            observe(EV_ERR, 0);
            checkOutput("err_busy", int'(m_if.busy), 0);
         end
      end
   end

   // Small-parameter instance observation.
   int s_rounds = 0;
   int s_words[$];
   int s_last_hs = -1;
   int s_done_cyc = -1;
   int s_done_cnt = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (s_if.round_en) s_rounds++;
         if (s_if.out_valid && s_if.out_ready) begin
            s_words.push_back(int'(s_if.out_idx));
            s_last_hs = cyc;
         end
         if (s_if.done) begin s_done_cyc = cyc; s_done_cnt++; end
      end
   end

   task automatic applyStimulus(bit first, bit last, int stop_at, bit use_reset);
      bit timed_out;
      pushModel(first, last, stop_at, use_reset);
      @(posedge clk); #1;
      m_if.start = 1'b1;
      m_if.first_block = first;
      m_if.last_block = last;
      @(posedge clk); #1;
      m_if.start = 1'b0;
      timed_out = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (!m_if.busy) begin timed_out = 1'b0; break; end
         if (stop_at >= 0 && m_if.round_en && int'(m_if.round_idx) == stop_at) begin
            if (use_reset) begin
               reset_n = 1'b0;
               repeat (2) @(posedge clk);
               #1 reset_n = 1'b1;
               repeat (3) @(posedge clk);
               #1;
            end else begin
               m_if.abort = 1'b1;
               @(posedge clk); #1;
               m_if.abort = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      if (timed_out) checkOutput("block_timeout", 1, 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int c0;
      m_if.start = 1'b0; m_if.first_block = 1'b0; m_if.last_block = 1'b0; m_if.abort = 1'b0;
      s_if.start = 1'b0; s_if.first_block = 1'b0; s_if.last_block = 1'b0; s_if.abort = 1'b0;
      s_if.in_valid = 1'b1; s_if.out_ready = 1'b1;

      // Reset state
      #23;
      checkOutput("rst_busy", int'(m_if.busy), 0);
      checkOutput("rst_in_ready", int'(m_if.in_ready), 0);
      checkOutput("rst_round_en", int'(m_if.round_en), 0);
      checkOutput("rst_round_idx", int'(m_if.round_idx), 0);
      checkOutput("rst_out_valid", int'(m_if.out_valid), 0);
      checkOutput("rst_out_idx", int'(m_if.out_idx), 0);
      checkOutput("rst_pulses", int'({m_if.init_hash, m_if.update_hash, m_if.done, m_if.err}), 0);

      // A start during the release window must be ignored
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_if.start = 1'b1; m_if.first_block = 1'b1; m_if.last_block = 1'b1;
      @(posedge clk); #1;
      m_if.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("sync_ignore_busy", int'(m_if.busy), 0);

      // Continuation with no open message is rejected
      applyStimulus(1'b0, 1'b1, -1, 1'b0);

      // Single block latency with free-flowing handshakes
      t_init = -1; t_r0 = -1; t_rlast = -1; t_upd = -1; t_o0 = -1; t_olast = -1; t_done = -1;
      iv_mode = 0; or_mode = 0;
      pushModel(1'b1, 1'b1, -1, 1'b0);
      @(posedge clk); #1;
      m_if.start = 1'b1; m_if.first_block = 1'b1; m_if.last_block = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      m_if.start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      checkOutput("lat_init", t_init - c0, 1);
      checkOutput("lat_round0", t_r0 - c0, LW + 1);
      checkOutput("lat_round_last", t_rlast - c0, LW + R);
      checkOutput("lat_update", t_upd - c0, LW + R + 1);
      checkOutput("lat_out0", t_o0 - c0, LW + R + 2);
      checkOutput("lat_out_last", t_olast - c0, LW + R + DW + 1);
      checkOutput("lat_done", t_done - c0, LW + R + DW + 2);

      // Two-block message
      applyStimulus(1'b1, 1'b0, -1, 1'b0);
      applyStimulus(1'b0, 1'b1, -1, 1'b0);

      // Gappy input and a three-cycle stall at digest word 4
      iv_mode = 1; or_mode = 1; hold_cnt = 0; stall4 = 0;
      applyStimulus(1'b1, 1'b1, -1, 1'b0);
      checkOutput("stall_at_idx4", stall4, 3);
      iv_mode = 0; or_mode = 0;

      // Abort mid-rounds, then a continuation must be rejected
      applyStimulus(1'b1, 1'b0, 30, 1'b0);
      applyStimulus(1'b0, 1'b1, -1, 1'b0);

      // Abort beats a simultaneous start
      @(posedge clk); #1;
      m_if.start = 1'b1; m_if.first_block = 1'b1; m_if.abort = 1'b1;
      @(posedge clk); #1;
      m_if.start = 1'b0; m_if.abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("abort_beats_start", int'(m_if.busy), 0);

      // Reset mid-rounds discards the block and closes the message
      applyStimulus(1'b1, 1'b0, 10, 1'b1);
      applyStimulus(1'b0, 1'b1, -1, 1'b0);

      // Randomised blocks
      for (int n = 0; n < 10; n++) begin
         bit f, l;
         int ab;
         f = ($urandom % 4) != 0;
         l = 1'($urandom % 2);
         ab = ($urandom % 5 == 0) ? int'($urandom % R) : -1;
         iv_mode = int'($urandom % 3);
         or_mode = ($urandom % 2 == 0) ? 2 : 0;
         applyStimulus(f, l, ab, 1'b0);
      end
      iv_mode = 0; or_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("leftover_events", exp_q.size(), 0);

      // Small parameter set on the second instance
      @(posedge clk); #1;
      s_if.start = 1'b1; s_if.first_block = 1'b1; s_if.last_block = 1'b1;
      @(posedge clk); #1;
      s_if.start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      checkOutput("small_rounds", s_rounds, 8);
      checkOutput("small_word_count", s_words.size(), 5);
      for (int i = 0; i < s_words.size(); i++) checkOutput("small_word_idx", s_words[i], i);
      checkOutput("small_done_count", s_done_cnt, 1);
      checkOutput("small_done_timing", s_done_cyc - s_last_hs, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
